// File: rtl/ids_bus_pkg.sv
// ids_bus_pkg: shared enums and size encodings for the IDS bus arbiter
package ids_bus_pkg;
    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
    localparam logic [3:0] SIZE_B = 4'b0001;
    localparam logic [3:0] SIZE_H = 4'b0011;
    localparam logic [3:0] SIZE_W = 4'b1111;
endpackage

// File: rtl/ids_rr_picker.sv
// ids_rr_picker: combinational N-way picker searching from ptr+1 with wrap-around
module ids_rr_picker
    import ids_bus_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // scan the search order backwards so the first hit after ptr is the last one written
    always_comb begin
        idx = '0;
        for (int i = N; i >= 1; i--)
            if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/ids_bus_arb.sv
// ids_bus_arb: N-master arbiter with fixed/round-robin selection and hold-limit pre-emption
module ids_bus_arb
    import ids_bus_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int N_MASTERS = 4,
    parameter int ARB_MODE = 1,
    parameter int MAX_HOLD = 16,
    localparam int OW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1,
    localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_MASTERS-1:0]      i_req,
    output logic [N_MASTERS-1:0]      o_gnt,
    input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
    input  logic [N_MASTERS*XLEN-1:0] i_m_wdata,
    input  logic [N_MASTERS*4-1:0]    i_m_size,
    input  logic [N_MASTERS-1:0]      i_m_read,
    input  logic [N_MASTERS-1:0]      i_m_write,
    output logic [XLEN-1:0]           o_m_rdata,
    output logic [N_MASTERS-1:0]      o_m_rvalid,
    output logic [XLEN-1:0]           o_s_addr,
    output logic [XLEN-1:0]           o_s_wdata,
    output logic [3:0]                o_s_size,
    output logic                      o_s_read,
    output logic                      o_s_write,
    input  logic [XLEN-1:0]           i_s_rdata,
    output logic [OW-1:0]             o_owner,
    output logic                      o_busy
);
    arb_state_e state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d, rd_owner_q, pick_req, pick_gnt, others;
    logic [OW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick_idx, pick_ptr;
    logic [HW-1:0] hold_q, hold_d;
    logic pick_any, expired, keep;

    ids_rr_picker #(.N(N_MASTERS)) u_pick (
        .req(pick_req),
        .ptr(pick_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    // next grant: keep the owner unless it releases or its hold expires while others wait
    always_comb begin
        others = i_req & ~gnt_q;
        pick_req = state_q == OWNED ? others : i_req;
        pick_ptr = ARB_MODE == int'(ARB_RR) ? rr_ptr_q : OW'(N_MASTERS - 1);
        expired = MAX_HOLD != 0 && int'(hold_q) >= MAX_HOLD - 1;
        keep = state_q == OWNED && i_req[owner_q] && !(expired && |others);
        state_d = keep || pick_any ? OWNED : IDLE;
        gnt_d = keep ? gnt_q : pick_gnt;
        owner_d = keep ? owner_q : pick_idx;
        rr_ptr_d = !keep && pick_any ? pick_idx : rr_ptr_q;
        hold_d = keep ? (int'(hold_q) < MAX_HOLD ? hold_q + 1'b1 : hold_q) : '0;
    end

    // arbitration state and read-return owner registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q <= '0;
            owner_q <= '0;
            rr_ptr_q <= OW'(N_MASTERS - 1);
            hold_q <= '0;
            rd_owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            owner_q <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q <= hold_d;
            rd_owner_q <= gnt_q & i_m_read;
        end
    end

    assign o_gnt = gnt_q;
    assign o_owner = owner_q;
    assign o_busy = |gnt_q;
    assign o_m_rvalid = rd_owner_q;
    assign o_m_rdata = i_s_rdata;
    assign o_s_read = |(gnt_q & i_m_read);
    assign o_s_write = |(gnt_q & i_m_write);
    assign o_s_addr = o_busy ? i_m_addr[owner_q*XLEN +: XLEN] : '0;
    assign o_s_wdata = o_busy ? i_m_wdata[owner_q*XLEN +: XLEN] : '0;
    assign o_s_size = o_busy ? i_m_size[owner_q*4 +: 4] : '0;
endmodule

// File: tb/tb_ids_bus_arb.sv
// tb_ids_bus_arb: round-robin and fixed-priority arbiters checked against a cycle-count model
module tb_ids_bus_arb;
    logic clk, rst;
    logic [3:0] req, m_read, m_write;
    logic [127:0] m_addr, m_wdata;
    logic [15:0] m_size;
    logic [31:0] s_rdata;
    logic [3:0] gnt [2];
    logic [3:0] rvalid [2];
    logic [3:0] s_size [2];
    logic [1:0] owner [2];
    logic busy [2];
    logic s_read [2];
    logic s_write [2];
    logic [31:0] rdata [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_wdata [2];
    int own [2];
    int cnt [2];
    int last [2];
    logic [3:0] rd [2];
    int passed = 0, total = 0, fails = 0;

    ids_bus_arb #(.XLEN(32), .N_MASTERS(4), .ARB_MODE(1), .MAX_HOLD(16)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt[0]),
        .i_m_addr(m_addr), .i_m_wdata(m_wdata), .i_m_size(m_size),
        .i_m_read(m_read), .i_m_write(m_write),
        .o_m_rdata(rdata[0]), .o_m_rvalid(rvalid[0]),
        .o_s_addr(s_addr[0]), .o_s_wdata(s_wdata[0]), .o_s_size(s_size[0]),
        .o_s_read(s_read[0]), .o_s_write(s_write[0]), .i_s_rdata(s_rdata),
        .o_owner(owner[0]), .o_busy(busy[0])
    );

    ids_bus_arb #(.XLEN(32), .N_MASTERS(4), .ARB_MODE(0), .MAX_HOLD(0)) u_fx (
        .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt[1]),
        .i_m_addr(m_addr), .i_m_wdata(m_wdata), .i_m_size(m_size),
        .i_m_read(m_read), .i_m_write(m_write),
        .o_m_rdata(rdata[1]), .o_m_rvalid(rvalid[1]),
        .o_s_addr(s_addr[1]), .o_s_wdata(s_wdata[1]), .o_s_size(s_size[1]),
        .o_s_read(s_read[1]), .o_s_write(s_write[1]), .i_s_rdata(s_rdata),
        .o_owner(owner[1]), .o_busy(busy[1])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int pick(input int md, input logic [3:0] c, input int lst);
        pick = -1;
        for (int i = 4; i >= 1; i--) begin
            int k;
            k = md != 0 ? (lst + i) % 4 : i - 1;
            if (c[k]) pick = k;
        end
    endfunction

    // reference: owner index (-1 idle) plus number of cycles it has held the bus
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            int md, lim, o, n;
            logic [3:0] oth;
            md = d == 0 ? 1 : 0;
            lim = d == 0 ? 16 : 0;
            o = own[d];
            if (rst) begin
                own[d] <= -1;
                cnt[d] <= 0;
                last[d] <= 3;
                rd[d] <= '0;
            end else begin
                oth = o < 0 ? req : req & ~(4'b1 << o);
                if (o >= 0 && req[o] && !(lim != 0 && cnt[d] >= lim && oth != 0)) begin
                    cnt[d] <= cnt[d] + 1;
                end else begin
                    n = oth != 0 ? pick(md, oth, last[d]) : -1;
                    own[d] <= n;
                    cnt[d] <= 1;
                    if (n >= 0) last[d] <= n;
                end
                rd[d] <= (o >= 0 && m_read[o]) ? 4'b1 << o : 4'b0;
            end
        end
    end

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int o;
            o = own[d];
            chk("gnt", d, 32'(gnt[d]), o < 0 ? 32'd0 : 32'd1 << o);
            chk("owner", d, 32'(owner[d]), o < 0 ? 32'd0 : 32'(o));
            chk("busy", d, 32'(busy[d]), o < 0 ? 32'd0 : 32'd1);
            chk("s_addr", d, s_addr[d], o < 0 ? 32'd0 : m_addr[o*32 +: 32]);
            chk("s_wdata", d, s_wdata[d], o < 0 ? 32'd0 : m_wdata[o*32 +: 32]);
            chk("s_size", d, 32'(s_size[d]), o < 0 ? 32'd0 : 32'(m_size[o*4 +: 4]));
            chk("s_read", d, 32'(s_read[d]), o < 0 ? 32'd0 : 32'(m_read[o]));
            chk("s_write", d, 32'(s_write[d]), o < 0 ? 32'd0 : 32'(m_write[o]));
            chk("rvalid", d, 32'(rvalid[d]), 32'(rd[d]));
            chk("rdata", d, rdata[d], s_rdata);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1;
        req = '0;
        m_read = '0;
        m_write = '0;
        m_addr = '0;
        m_wdata = '0;
        m_size = '0;
        s_rdata = '0;
        repeat (2) cyc();
        rst = 0;
        cyc();
        req = 4'b0001;
        #1;
        chk("gnt_req_cycle", 0, 32'(gnt[0]), 32'd0);
        chk("gnt_req_cycle", 1, 32'(gnt[1]), 32'd0);
        cyc();
        chk("first_gnt", 0, 32'(gnt[0]), 32'b0001);
        chk("first_busy", 0, 32'(busy[0]), 32'd1);
        req = 4'b1111;
        repeat (70) cyc();
        req = 4'b0110;
        repeat (5) cyc();
        chk("fixed_m1", 1, 32'(gnt[1]), 32'b0010);
        req = 4'b0100;
        cyc();
        chk("fixed_handover", 1, 32'(gnt[1]), 32'b0100);
        repeat (3) cyc();
        req = 4'b0000;
        repeat (2) cyc();
        req = 4'b0100;
        cyc();
        req = 4'b1100;
        repeat (15) cyc();
        m_read = 4'b0100;
        m_addr[95:64] = 32'h4000_0040;
        s_rdata = 32'hDEAD_BEEF;
        #1;
        chk("last_cycle_addr", 0, s_addr[0], 32'h4000_0040);
        cyc();
        chk("preempt_gnt", 0, 32'(gnt[0]), 32'b1000);
        chk("preempt_rvalid", 0, 32'(rvalid[0]), 32'b0100);
        chk("preempt_rdata", 0, rdata[0], 32'hDEAD_BEEF);
        m_read = 4'b0000;
        m_write = 4'b1000;
        m_addr[127:96] = 32'h8000_0008;
        #1;
        chk("ungranted_write", 1, 32'(s_write[1]), 32'd0);
        chk("ungranted_addr", 1, s_addr[1], 32'h4000_0040);
        cyc();
        m_write = 4'b1100;
        m_read = 4'b1100;
        cyc();
        chk("write_before_rst", 0, 32'(s_write[0]), 32'd1);
        chk("write_before_rst", 1, 32'(s_write[1]), 32'd1);
        #2;
        rst = 1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", d, 32'(gnt[d]), 32'd0);
            chk("rst_write", d, 32'(s_write[d]), 32'd0);
            chk("rst_rvalid", d, 32'(rvalid[d]), 32'd0);
        end
        cyc();
        m_write = '0;
        m_read = '0;
        rst = 0;
        repeat (400) begin
            if ($urandom_range(11) == 0) req = 4'($urandom);
            m_read = 4'($urandom);
            m_write = 4'($urandom);
            m_addr = {$urandom, $urandom, $urandom, $urandom};
            m_wdata = {$urandom, $urandom, $urandom, $urandom};
            m_size = 16'($urandom);
            s_rdata = $urandom;
            cyc();
        end
        if (fails != 0) $display("%0d comparisons differed", fails);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
